// File: rtl/test_port_writer_if.sv
// rtl/test_port_writer_if.sv - result stream and data-memory write bus bundle for test_port_writer
interface test_port_writer_if;
  // result stream from the producer (e.g. MultDiv unit)
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  // data-memory write bus toward the test port
  logic        mem_stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;

  // writer side: consumes results, drives the write bus
  modport master (
    input  res_valid,
    input  res_data,
    input  mem_stall,
    output res_ready,
    output addr,
    output data,
    output wen
  );

  // environment side: result source plus memory
  modport slave (
    output res_valid,
    output res_data,
    output mem_stall,
    input  res_ready,
    input  addr,
    input  data,
    input  wen
  );
endinterface

// File: rtl/test_port_writer.sv
// rtl/test_port_writer.sv - frames a result stream as BEGIN/results/END test-port writes; TPW_CHECKSUM_EN adds an XOR checksum word
module test_port_writer #(
  parameter logic [29:0] TEST_PORT   = 30'h40,
  parameter logic [31:0] BEGIN_SYM   = 32'h0000_0932,
  parameter logic [31:0] END_SYM     = 32'h0000_0D5D,
  parameter int          NUM_RESULTS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  test_port_writer_if.master bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEGIN,
    S_DATA,
`ifdef TPW_CHECKSUM_EN
    S_CSUM,
`endif
    S_END
  } state_t;

  localparam logic [7:0] NUM_LAST = 8'(NUM_RESULTS);

  state_t      state;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic        wen_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  count_q;
`ifdef TPW_CHECKSUM_EN
  logic [31:0] xor_q;
`endif

  logic write_done;
  logic res_ready_c;
  logic accept;

  // A presented write retires on any edge where memory is not stalling.
  assign write_done = wen_q && !bus.mem_stall;

  // The first result may be taken on the edge that retires BEGIN_SYM so the
  // frame runs without a bubble; otherwise results are only taken in DATA.
  // A slot is free when nothing is presented or the presented word retires.
  assign res_ready_c = ((state == S_BEGIN) || (state == S_DATA))
                       && (!wen_q || !bus.mem_stall)
                       && (count_q < NUM_LAST);
  assign accept      = bus.res_valid && res_ready_c;

  assign bus.res_ready = res_ready_c;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.wen       = wen_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Frame sequencer: all bus outputs and status are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= 30'h0;
      data_q  <= 32'h0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 8'h0;
`ifdef TPW_CHECKSUM_EN
      xor_q   <= 32'h0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_BEGIN;
            wen_q   <= 1'b1;
            addr_q  <= TEST_PORT;
            data_q  <= BEGIN_SYM;
            busy_q  <= 1'b1;
            count_q <= 8'h0;
`ifdef TPW_CHECKSUM_EN
            xor_q   <= 32'h0;
`endif
          end
        end

        S_BEGIN, S_DATA: begin
          if (accept) begin
            // Accepting implies the previous write (if any) retires now.
            state   <= S_DATA;
            wen_q   <= 1'b1;
            addr_q  <= TEST_PORT;
            data_q  <= bus.res_data;
            count_q <= count_q + 8'd1;
`ifdef TPW_CHECKSUM_EN
            xor_q   <= xor_q ^ bus.res_data;
`endif
          end else if (write_done) begin
            if ((state == S_DATA) && (count_q == NUM_LAST)) begin
              // Last result retired: present the trailer without a gap.
`ifdef TPW_CHECKSUM_EN
              state  <= S_CSUM;
              data_q <= xor_q;
`else
              state  <= S_END;
              data_q <= END_SYM;
`endif
            end else begin
              state  <= S_DATA;
              wen_q  <= 1'b0;
              addr_q <= 30'h0;
            end
          end
        end

`ifdef TPW_CHECKSUM_EN
        S_CSUM: begin
          if (write_done) begin
            state  <= S_END;
            data_q <= END_SYM;
          end
        end
`endif

        S_END: begin
          if (write_done) begin
            state  <= S_IDLE;
            wen_q  <= 1'b0;
            addr_q <= 30'h0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          wen_q  <= 1'b0;
          addr_q <= 30'h0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
